mips_mem_responder: RTL and testbench
=====================================

Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core's unified memory port. The core's control FSM is the initiator; this block is the responding end.
- Services single-word read/write requests from the core. Decodes the address into a data RAM region, a GPIO output register and a synchronized GPIO input register.
- Returns data with a one-cycle ready pulse after a configurable number of wait states. Flags misaligned or unmapped accesses.

Parameters:
- WIDTH, 32, data/address width.
- RAM_DEPTH, 64, data RAM size in words (power of 2).
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15).
- RAM_BASE, 32'h1001_0000, byte address of RAM word 0.
- GPIO_OUT_ADDR, 32'h1001_0100, byte address of the GPIO output register (read/write).
- GPIO_IN_ADDR, 32'h1001_0104, byte address of the GPIO input register (read-only).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  request strobe from the core; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  WIDTH  byte address; sampled with req.
- wdata  input  WIDTH  write data; sampled with req.
- rdata  output  WIDTH  read data; valid while ready=1.
- ready  output  1  one-cycle response pulse.
- err  output  1  error status; valid while ready=1.
- gpio_in  input  WIDTH  asynchronous external inputs.
- gpio_out  output  WIDTH  registered GPIO output.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rdata=0, ready=0, err=0, gpio_out=0, wait counter=0, GPIO synchronizer flops=0. RAM contents are not reset.
- Reset mid-transaction: the transaction is aborted and no write is committed.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if req=1, latch we/addr/wdata. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: the counter counts WAIT_CYCLES cycles, then go to RESP.
  - RESP: ready=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: with req high in cycle 0, ready is high in cycle 1+WAIT_CYCLES.
  - WAIT_CYCLES=1: ready in cycle 2.
  - WAIT_CYCLES=0: ready in cycle 1.
- Back-to-back: req is ignored in WAIT and RESP. A req held high through RESP is re-accepted in the following IDLE cycle, so there is a minimum of one IDLE cycle between transactions.
- Changes to addr/wdata/we after acceptance have no effect.
- Decode, on the latched address:
  - RAM hit: RAM_BASE <= addr < RAM_BASE+4*RAM_DEPTH. Word index = (addr-RAM_BASE)>>2.
  - GPIO_OUT hit: addr == GPIO_OUT_ADDR.
  - GPIO_IN hit: addr == GPIO_IN_ADDR.
- Errors: addr[1:0]!=0, or an address matching no region, gives err=1 in RESP, rdata=0 and no state change. Misalignment takes priority.
- A write to GPIO_IN_ADDR is ignored with err=0.
- Reads: rdata is loaded on the edge entering RESP, from one of:
  - the RAM word;
  - the gpio_out register;
  - the 2-flop synchronized gpio_in.
  - All other cases give rdata=0.
- Writes: committed on the edge entering RESP (RAM word or gpio_out). rdata=0 for writes.
  - A read of the same address in the next transaction returns the new value.
- GPIO input: a 2-flop synchronizer that is always running. Input-to-visible latency is 2 clocks.
- ready and err are 0 in every state other than RESP.

Test Plan:
- Reset values: assert rst=0 mid-WAIT of a write (addr 0x10010000, data 0xDEADBEEF), then release and read 0x10010000 -> the write is aborted. Check gpio_out=0, ready=0, and that no ready pulse is produced for the aborted request.
- RAM write then read, WAIT_CYCLES=1:
  - Write 0x10010010 <- 0x12345678 -> ready in cycle 2, err=0.
  - Read 0x10010010 -> rdata=0x12345678 with ready.
  - Read 0x100100FC (last word) after writing it 0xA5A5A5A5 -> 0xA5A5A5A5.
- GPIO:
  - Write 0x10010100 <- 0x000000FF -> gpio_out=0x000000FF after the RESP edge.
  - Read 0x10010100 -> 0xFF.
  - Set gpio_in=0x5 -> a read of 0x10010104 issued ≥2 clocks later returns 0x5.
- Errors:
  - Read 0x10010002 -> ready=1, err=1, rdata=0.
  - Write 0x10010200 <- 0x1 -> err=1 and no RAM/gpio_out change.
  - Write 0x10010104 -> err=0 and no effect.
- Handshake: hold req=1 continuously with alternating addresses, WAIT_CYCLES=0 -> ready pulses every 2nd cycle (1 high, 1 low). Changing addr during WAIT (WAIT_CYCLES=3) does not alter the returned rdata.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core's unified memory port.
// Accepts one read/write request at a time, decodes it into data RAM,
// GPIO output register or synchronized GPIO input, and answers with a
// one-cycle ready pulse after WAIT_CYCLES wait states.
//
// Handshake: req/we/addr/wdata are sampled only while IDLE; everything is
// captured on the accepting edge, so later changes have no effect. The
// response is a single-cycle ready pulse with rdata/err valid in that same
// cycle; req is ignored in WAIT and RESP, so back-to-back requests are
// always separated by at least one IDLE cycle.
module mips_mem_responder #(
    parameter int unsigned      WIDTH         = 32,
    parameter int unsigned      RAM_DEPTH     = 64,
    parameter int unsigned      WAIT_CYCLES   = 1,
    parameter logic [WIDTH-1:0] RAM_BASE      = 32'h1001_0000,
    parameter logic [WIDTH-1:0] GPIO_OUT_ADDR = 32'h1001_0100,
    parameter logic [WIDTH-1:0] GPIO_IN_ADDR  = 32'h1001_0104
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             err,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out
);

    localparam int unsigned      IDX_W     = $clog2(RAM_DEPTH);
    localparam logic [WIDTH-1:0] RAM_BYTES = WIDTH'(4 * RAM_DEPTH);
    localparam logic [3:0]       WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;

    logic [WIDTH-1:0] mem [RAM_DEPTH];

    // Transaction fields: live inputs while IDLE (needed when WAIT_CYCLES=0
    // so the response edge is also the accepting edge), latched copies after.
    logic             cur_we;
    logic [WIDTH-1:0] cur_addr;
    logic [WIDTH-1:0] cur_wdata;
    logic [WIDTH-1:0] ram_off;
    logic [IDX_W-1:0] ram_idx;
    logic             misaligned, ram_hit, gout_hit, gin_hit;
    logic             enter_resp, ram_we;

    // Select the active transaction fields and decode the address.
    always_comb begin
        cur_we     = (state_q == ST_IDLE) ? we    : we_q;
        cur_addr   = (state_q == ST_IDLE) ? addr  : addr_q;
        cur_wdata  = (state_q == ST_IDLE) ? wdata : wdata_q;
        ram_off    = cur_addr - RAM_BASE;
        ram_idx    = ram_off[IDX_W+1:2];
        misaligned = (cur_addr[1:0] != 2'b00);
        ram_hit    = (cur_addr >= RAM_BASE) && (ram_off < RAM_BYTES);
        gout_hit   = (cur_addr == GPIO_OUT_ADDR);
        gin_hit    = (cur_addr == GPIO_IN_ADDR);
        enter_resp = ((state_q == ST_IDLE) && req && (WAIT_CYCLES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == WAIT_LAST));
        // rst gating keeps a request seen during reset from touching the RAM.
        ram_we     = rst && enter_resp && cur_we && !misaligned && ram_hit;
    end

    // Next-state, response and GPIO logic for every registered signal.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        gpio_out_d = gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = ST_RESP;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Everything visible in RESP is loaded on the edge that enters it.
        if (enter_resp) begin
            ready_d = 1'b1;
            rdata_d = '0;
            if (misaligned) begin
                err_d = 1'b1;
            end else if (ram_hit) begin
                if (!cur_we) rdata_d = mem[ram_idx];
            end else if (gout_hit) begin
                if (cur_we) gpio_out_d = cur_wdata;
                else        rdata_d    = gpio_out_q;
            end else if (gin_hit) begin
                if (!cur_we) rdata_d = sync2_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State, outputs and the always-running gpio_in synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
        end
    end

    // Data RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= cur_wdata;
    end

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign gpio_out = gpio_out_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed testbench for mips_mem_responder: three instances with
// WAIT_CYCLES = 0, 1 and 3 share clock, reset and request fields.
module tb_mips_mem_responder;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] gpio_in;
    logic        req0, req1, req3;
    logic [31:0] rdata0, rdata1, rdata3;
    logic        ready0, ready1, ready3;
    logic        err0, err1, err3;
    logic [31:0] gpio_out0, gpio_out1, gpio_out3;

    int checks = 0;
    int errors = 0;
    int sel    = 1;

    logic        cur_ready, cur_err;
    logic [31:0] cur_rdata;

    assign cur_ready = (sel == 0) ? ready0 : (sel == 1) ? ready1 : ready3;
    assign cur_err   = (sel == 0) ? err0   : (sel == 1) ? err1   : err3;
    assign cur_rdata = (sel == 0) ? rdata0 : (sel == 1) ? rdata1 : rdata3;

    mips_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .err(err0), .gpio_in(gpio_in), .gpio_out(gpio_out0)
    );
    mips_mem_responder #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .ready(ready1), .err(err1), .gpio_in(gpio_in), .gpio_out(gpio_out1)
    );
    mips_mem_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .ready(ready3), .err(err3), .gpio_in(gpio_in), .gpio_out(gpio_out3)
    );

    // Clock and global watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: issue one request to instance d starting in the current IDLE
    // cycle (called #1 after a rising edge). After acceptance the request
    // fields are flipped to prove they are not re-sampled. Returns the
    // response and the cycle number of the ready pulse (request cycle = 0).
    task automatic txn(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic e, output int lat);
        sel   = d;
        we    = w;
        addr  = a;
        wdata = wd;
        req0  = (d == 0);
        req1  = (d == 1);
        req3  = (d == 3);
        @(posedge clk); #1;
        req0  = 1'b0;
        req1  = 1'b0;
        req3  = 1'b0;
        we    = ~w;
        addr  = a ^ 32'h0000_0004;
        wdata = ~wd;
        lat   = 1;
        while (!cur_ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = cur_rdata;
        e  = cur_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic e; int lat; int pulses;
        rst = 1'b0; req0 = 0; req1 = 0; req3 = 0;
        we = 0; addr = '0; wdata = '0; gpio_in = '0;
        repeat (3) @(posedge clk); #1;
        checks++; if (ready1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 32'h0) begin
            errors++; $display("FAIL reset_outputs: ready=%b err=%b rdata=%h, want 0/0/0", ready1, err1, rdata1); end
        rst = 1'b1;
        @(posedge clk); #1;
        txn(1, 1'b1, 32'h1001_0000, 32'h0BAD_F00D, rd, e, lat);
        txn(1, 1'b1, 32'h1001_0100, 32'h0000_003C, rd, e, lat);
        txn(1, 1'b0, 32'h1001_0000, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL reset_preload: rdata=%h want 0badf00d", rd); end
        // Start a write, then assert reset while it sits in WAIT.
        sel = 1; we = 1'b1; addr = 32'h1001_0000; wdata = 32'hDEAD_BEEF; req1 = 1'b1;
        @(posedge clk); #1;
        req1 = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (gpio_out1 !== 32'h0 || ready1 !== 1'b0 || rdata1 !== 32'h0) begin
            errors++; $display("FAIL reset_async: gpio_out=%h ready=%b rdata=%h, want 0/0/0", gpio_out1, ready1, rdata1); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready1) pulses++;
        end
        checks++; if (pulses !== 0) begin
            errors++; $display("FAIL reset_no_pulse: ready pulses=%0d want 0", pulses); end
        txn(1, 1'b0, 32'h1001_0000, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL reset_abort: rdata=%h want 0badf00d", rd); end
    endtask

    task automatic test_ram();
        logic [31:0] rd; logic e; int lat;
        txn(1, 1'b1, 32'h1001_0010, 32'h1234_5678, rd, e, lat);
        checks++; if (lat !== 2 || e !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL ram_write: lat=%0d err=%b rdata=%h want 2/0/0", lat, e, rd); end
        txn(1, 1'b0, 32'h1001_0010, 32'h0, rd, e, lat);
        checks++; if (lat !== 2 || e !== 1'b0 || rd !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_read: lat=%0d err=%b rdata=%h want 2/0/12345678", lat, e, rd); end
        txn(1, 1'b1, 32'h1001_00FC, 32'hA5A5_A5A5, rd, e, lat);
        txn(1, 1'b0, 32'h1001_00FC, 32'h0, rd, e, lat);
        checks++; if (e !== 1'b0 || rd !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL ram_last_word: err=%b rdata=%h want 0/a5a5a5a5", e, rd); end
        txn(1, 1'b0, 32'h1001_0010, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL ram_no_alias: rdata=%h want 12345678", rd); end
    endtask

    task automatic test_gpio();
        logic [31:0] rd; logic e; int lat;
        txn(1, 1'b1, 32'h1001_0100, 32'h0000_00FF, rd, e, lat);
        checks++; if (gpio_out1 !== 32'h0000_00FF || e !== 1'b0) begin
            errors++; $display("FAIL gpio_out_write: gpio_out=%h err=%b want 000000ff/0", gpio_out1, e); end
        txn(1, 1'b0, 32'h1001_0100, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h0000_00FF || e !== 1'b0) begin
            errors++; $display("FAIL gpio_out_read: rdata=%h err=%b want 000000ff/0", rd, e); end
        gpio_in = 32'h0000_0005;
        repeat (2) @(posedge clk); #1;
        txn(1, 1'b0, 32'h1001_0104, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h0000_0005 || e !== 1'b0) begin
            errors++; $display("FAIL gpio_in_read: rdata=%h err=%b want 00000005/0", rd, e); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        txn(1, 1'b0, 32'h1001_0002, 32'h0, rd, e, lat);
        checks++; if (lat !== 2 || e !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL err_misaligned_read: lat=%0d err=%b rdata=%h want 2/1/0", lat, e, rd); end
        txn(1, 1'b1, 32'h1001_0200, 32'h0000_0001, rd, e, lat);
        checks++; if (e !== 1'b1 || gpio_out1 !== 32'h0000_00FF) begin
            errors++; $display("FAIL err_unmapped_write: err=%b gpio_out=%h want 1/000000ff", e, gpio_out1); end
        txn(1, 1'b1, 32'h1001_0011, 32'hFFFF_FFFF, rd, e, lat);
        checks++; if (e !== 1'b1) begin
            errors++; $display("FAIL err_misaligned_ram_write: err=%b want 1", e); end
        txn(1, 1'b0, 32'h1001_0010, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h1234_5678) begin
            errors++; $display("FAIL err_ram_untouched: rdata=%h want 12345678", rd); end
        txn(1, 1'b1, 32'h1001_0104, 32'h0000_0077, rd, e, lat);
        checks++; if (e !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL gpio_in_write_ignored: err=%b rdata=%h want 0/0", e, rd); end
        txn(1, 1'b0, 32'h1001_0104, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'h0000_0005 || gpio_out1 !== 32'h0000_00FF) begin
            errors++; $display("FAIL gpio_in_write_no_effect: rdata=%h gpio_out=%h want 00000005/000000ff", rd, gpio_out1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat;
        logic [31:0] exp_d;
        txn(0, 1'b1, 32'h1001_0030, 32'h0000_AAAA, rd, e, lat);
        checks++; if (lat !== 1 || e !== 1'b0) begin
            errors++; $display("FAIL latency_wait0: lat=%0d err=%b want 1/0", lat, e); end
        txn(0, 1'b1, 32'h1001_0034, 32'h0000_5555, rd, e, lat);
        // req held high; address switches every two cycles.
        sel = 0; we = 1'b0; req0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            addr = (((k / 2) % 2) == 1) ? 32'h1001_0034 : 32'h1001_0030;
            checks++; if (ready0 !== ((k % 2) == 1)) begin
                errors++; $display("FAIL b2b_ready_c%0d: ready=%b want %b", k, ready0, ((k % 2) == 1)); end
            if ((k % 2) == 1) begin
                exp_d = ((((k - 1) / 2) % 2) == 1) ? 32'h0000_5555 : 32'h0000_AAAA;
                checks++; if (rdata0 !== exp_d) begin
                    errors++; $display("FAIL b2b_rdata_c%0d: rdata=%h want %h", k, rdata0, exp_d); end
            end
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_wait3();
        logic [31:0] rd; logic e; int lat;
        txn(3, 1'b1, 32'h1001_0020, 32'hCAFE_0001, rd, e, lat);
        txn(3, 1'b1, 32'h1001_0024, 32'hCAFE_0002, rd, e, lat);
        checks++; if (lat !== 4 || e !== 1'b0) begin
            errors++; $display("FAIL latency_wait3: lat=%0d err=%b want 4/0", lat, e); end
        txn(3, 1'b0, 32'h1001_0020, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'hCAFE_0001 || lat !== 4) begin
            errors++; $display("FAIL wait3_addr_change: rdata=%h lat=%0d want cafe0001/4", rd, lat); end
        txn(3, 1'b0, 32'h1001_0024, 32'h0, rd, e, lat);
        checks++; if (rd !== 32'hCAFE_0002) begin
            errors++; $display("FAIL wait3_read2: rdata=%h want cafe0002", rd); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio();
        test_errors();
        test_back_to_back();
        test_wait3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
